// File: rtl/mb_audio_conditioner.sv
// mb_audio_conditioner: per-channel one-pole IIR low-pass on PSG PCM, decimated
// to a fixed output sample rate, scaled by a 16-step volume, and buffered in a
// small show-ahead FIFO with a sticky overflow flag.
module mb_audio_conditioner #(
  parameter int SAMPLE_DIV   = 1125,
  parameter int FILTER_SHIFT = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk_logic,
  input  logic               reset,
  input  logic               en_i,
  input  logic signed [13:0] audio_l_i,
  input  logic signed [13:0] audio_r_i,
  input  logic [3:0]         volume_i,
  input  logic               mute_i,
  output logic signed [15:0] sample_l_o,
  output logic signed [15:0] sample_r_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               overflow_o
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  // One filter step; the difference is held in 21 bits because x - y can
  // span twice the 20-bit state range. The sum always lands between x and y.
  function automatic logic signed [19:0] iir_step(input logic signed [19:0] y,
                                                  input logic signed [13:0] x);
    logic signed [20:0] diff;
    logic signed [20:0] sum;
    diff = {x[13], x, 6'd0} - {y[19], y};
    diff = diff >>> FILTER_SHIFT;
    sum  = {y[19], y} + diff;
    return sum[19:0];
  endfunction

  // Volume scaling: top 16 bits of the state times (volume+1), divided by 16.
  // The largest magnitude product is 2^15 * 16, so 21 signed bits suffice and
  // the shifted result always fits 16 bits; volume 15 multiplies by exactly 1.
  function automatic logic signed [15:0] gain_apply(input logic signed [19:0] y,
                                                    input logic [3:0]         vol);
    logic signed [15:0] y_hi;
    logic signed [5:0]  k;
    logic signed [20:0] a21;
    logic signed [20:0] k21;
    logic signed [20:0] prod;
    y_hi = y[19:4];
    k    = $signed({2'b00, vol} + 6'd1);
    a21  = 21'(y_hi);
    k21  = 21'(k);
    prod = a21 * k21;
    return prod[19:4];
  endfunction

  logic signed [19:0] y_l_q, y_l_d, y_r_q, y_r_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic signed [15:0] g_l_q, g_l_d, g_r_q, g_r_d;
  logic               push_q, push_d;
  logic signed [15:0] mem_l_q [FIFO_DEPTH];
  logic signed [15:0] mem_l_d [FIFO_DEPTH];
  logic signed [15:0] mem_r_q [FIFO_DEPTH];
  logic signed [15:0] mem_r_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;

  logic tick_s, full_s, pop_s, push_ok_s, drop_s;

  assign tick_s    = (cnt_q == DIV_LAST);
  assign valid_o   = (count_q != {(AW + 1){1'b0}});
  assign full_s    = (count_q == DEPTH_C);
  assign pop_s     = valid_o & ready_i;
  assign push_ok_s = push_q & (~full_s | pop_s);
  assign drop_s    = push_q & full_s & ~pop_s;

  // Filter state advances only on PSG sample enables.
  always_comb begin
    if (en_i) begin
      y_l_d = iir_step(y_l_q, audio_l_i);
      y_r_d = iir_step(y_r_q, audio_r_i);
    end else begin
      y_l_d = y_l_q;
      y_r_d = y_r_q;
    end
  end

  // Output-rate divider; the tick cycle is the last count of each period.
  always_comb begin
    if (tick_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end
  end

  // Gain stage samples the pre-update filter state on tick and flags a push
  // for the following cycle.
  always_comb begin
    push_d = tick_s;
    if (tick_s) begin
      if (mute_i) begin
        g_l_d = 16'sd0;
        g_r_d = 16'sd0;
      end else begin
        g_l_d = gain_apply(y_l_q, volume_i);
        g_r_d = gain_apply(y_r_q, volume_i);
      end
    end else begin
      g_l_d = g_l_q;
      g_r_d = g_r_q;
    end
  end

  // FIFO bookkeeping: a pop frees a slot in the same cycle, so a full FIFO can
  // accept a push alongside a pop; a push with no room is dropped and latched.
  always_comb begin
    mem_l_d = mem_l_q;
    mem_r_d = mem_r_q;
    if (push_ok_s) begin
      mem_l_d[wr_ptr_q] = g_l_q;
      mem_r_d[wr_ptr_q] = g_r_q;
      wr_ptr_d          = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1'b1);
      2'b01:   count_d = count_q - (AW + 1)'(1'b1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Show-ahead head; outputs read as zero while the FIFO is empty.
  always_comb begin
    if (valid_o) begin
      sample_l_o = mem_l_q[rd_ptr_q];
      sample_r_o = mem_r_q[rd_ptr_q];
    end else begin
      sample_l_o = 16'sd0;
      sample_r_o = 16'sd0;
    end
  end

  assign overflow_o = overflow_q;

  // State registers; reset drops any pending push and all buffered samples.
  always_ff @(posedge clk_logic) begin
    if (reset) begin
      y_l_q      <= 20'sd0;
      y_r_q      <= 20'sd0;
      cnt_q      <= {CW{1'b0}};
      g_l_q      <= 16'sd0;
      g_r_q      <= 16'sd0;
      push_q     <= 1'b0;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW + 1){1'b0}};
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l_q[i] <= 16'sd0;
        mem_r_q[i] <= 16'sd0;
      end
    end else begin
      y_l_q      <= y_l_d;
      y_r_q      <= y_r_d;
      cnt_q      <= cnt_d;
      g_l_q      <= g_l_d;
      g_r_q      <= g_r_d;
      push_q     <= push_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_l_q    <= mem_l_d;
      mem_r_q    <= mem_r_d;
    end
  end

endmodule
